reorder_buffer: RTL

16-entry in-order reorder buffer for the out-of-order core. Rename/dispatch allocates one entry per cycle in program order and receives its ROB number. The complete stage marks entries done, with up to two results per cycle. Retirement happens strictly in order, one per cycle, and hands the retiring destination and old physical register to the architectural commit / free-list logic.

---
 rtl/reorder_buffer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - 16-entry reorder buffer: in-order dispatch, dual-port completion, in-order retire.
// Control state is async-reset; payload arrays are plain registers written only for live entries.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int PREG_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_valid,
  input  logic [PREG_W-1:0] disp_preg_dst,
  input  logic [PREG_W-1:0] disp_old_preg_dst,
  input  logic              disp_reg_write,
  input  logic              disp_mem_write,
  output logic              disp_ready,
  output logic [3:0]        disp_rob_num,
  input  logic              cmp0_valid,
  input  logic [3:0]        cmp0_rob_num,
  input  logic [DATA_W-1:0] cmp0_data,
  input  logic              cmp1_valid,
  input  logic [3:0]        cmp1_rob_num,
  input  logic [DATA_W-1:0] cmp1_data,
  output logic              ret_valid,
  output logic [3:0]        ret_rob_num,
  output logic [PREG_W-1:0] ret_preg_dst,
  output logic [PREG_W-1:0] ret_old_preg_dst,
  output logic [DATA_W-1:0] ret_data,
  output logic              ret_reg_write,
  output logic              ret_mem_write,
  output logic              full,
  output logic              empty
);

  localparam int CNT_W = 5;

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  complete_q;
  logic [DEPTH-1:0]  reg_write_q;
  logic [DEPTH-1:0]  mem_write_q;
  logic [PREG_W-1:0] preg_dst_q     [DEPTH];
  logic [PREG_W-1:0] old_preg_dst_q [DEPTH];
  logic [DATA_W-1:0] data_q         [DEPTH];

  logic [3:0]       head_q;
  logic [3:0]       tail_q;
  logic [CNT_W-1:0] count_q;

  logic disp_fire;
  logic ret_fire;
  logic cmp0_hit;
  logic cmp1_hit;

  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign disp_ready   = !full;
  assign disp_rob_num = tail_q;

  assign disp_fire = disp_valid && !full;
  assign ret_fire  = valid_q[head_q] && complete_q[head_q];

  // Validity is judged on registered state, so a completion aimed at the entry
  // being dispatched this cycle is dropped. Port 0 wins a same-entry collision.
  assign cmp0_hit = cmp0_valid && valid_q[cmp0_rob_num];
  assign cmp1_hit = cmp1_valid && valid_q[cmp1_rob_num] &&
                    !(cmp0_hit && (cmp0_rob_num == cmp1_rob_num));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q          <= '0;
      complete_q       <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      ret_valid        <= 1'b0;
      ret_rob_num      <= '0;
      ret_preg_dst     <= '0;
      ret_old_preg_dst <= '0;
      ret_data         <= '0;
      ret_reg_write    <= 1'b0;
      ret_mem_write    <= 1'b0;
    end else begin
      ret_valid <= ret_fire;
      if (ret_fire) begin
        ret_rob_num      <= head_q;
        ret_preg_dst     <= preg_dst_q[head_q];
        ret_old_preg_dst <= old_preg_dst_q[head_q];
        ret_data         <= data_q[head_q];
        ret_reg_write    <= reg_write_q[head_q];
        ret_mem_write    <= mem_write_q[head_q];
      end

      if (cmp1_hit) complete_q[cmp1_rob_num] <= 1'b1;
      if (cmp0_hit) complete_q[cmp0_rob_num] <= 1'b1;

      if (disp_fire) begin
        valid_q[tail_q]    <= 1'b1;
        complete_q[tail_q] <= 1'b0;
        tail_q             <= tail_q + 4'd1;
      end

      // Retire last so it overrides a late completion of the departing head.
      if (ret_fire) begin
        valid_q[head_q]    <= 1'b0;
        complete_q[head_q] <= 1'b0;
        head_q             <= head_q + 4'd1;
      end

      case ({disp_fire, ret_fire})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cmp1_hit) data_q[cmp1_rob_num] <= cmp1_data;
    if (cmp0_hit) data_q[cmp0_rob_num] <= cmp0_data;
    if (disp_fire) begin
      preg_dst_q[tail_q]     <= disp_preg_dst;
      old_preg_dst_q[tail_q] <= disp_old_preg_dst;
      reg_write_q[tail_q]    <= disp_reg_write;
      mem_write_q[tail_q]    <= disp_mem_write;
      data_q[tail_q]         <= '0;
    end
  end

endmodule
